mine_ctrl: RTL and testbench

//  Job sequencer between the host-written register file and the SHA-256d hash core.
//  On start: snapshots midstate/header_leftovers/target, sweeps nonces into the core via valid/ready.

---
 rtl/mine_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mine_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mine_ctrl.sv
`timescale 1ns/1ps
// mine_ctrl: job sequencer between the host register file and the SHA-256d core.
// On start it snapshots midstate/header/target, then sweeps nonces into the core
// over a valid/ready handshake and bounds the number of unreturned nonces. Each
// returned hash is compared against the target. The job stops on the first hit
// (after the remaining nonces drain), on nonce exhaustion, or on abort.
// Optional build macro MINE_CTRL_HASH_COUNT_EN adds a 48-bit saturating count of
// results received while a job is running.
module mine_ctrl #(
    parameter logic [31:0] NONCE_FIRST  = 32'h0000_0000,
    parameter logic [31:0] NONCE_LAST   = 32'hFFFF_FFFF,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [255:0] midstate_in,
    input  logic [95:0]  header_in,
    input  logic [255:0] target_in,
    output logic [255:0] job_midstate,
    output logic [95:0]  job_header,
    output logic         core_valid,
    input  logic         core_ready,
    output logic [31:0]  core_nonce,
    input  logic         res_valid,
    input  logic [31:0]  res_nonce,
    input  logic [255:0] res_hash,
    output logic [2:0]   state_out,
    output logic [31:0]  nonce_out,
    output logic         found
`ifdef MINE_CTRL_HASH_COUNT_EN
    ,
    output logic [47:0]  hash_count
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_FOUND     = 3'd4,
        ST_EXHAUSTED = 3'd5,
        ST_ABORTED   = 3'd6
    } state_t;

    localparam logic [3:0] MAX_INF = 4'(MAX_INFLIGHT);

    state_t         state_q, state_d;
    logic [255:0]   midstate_q, midstate_d;
    logic [95:0]    header_q, header_d;
    logic [255:0]   target_q, target_d;
    logic [31:0]    nonce_q, nonce_d;
    logic [31:0]    golden_q, golden_d;
    logic [3:0]     inflight_q, inflight_d;
    logic           last_issued_q, last_issued_d;
    logic [31:0]    nonce_out_q, nonce_out_d;
    logic           found_q, found_d;
`ifdef MINE_CTRL_HASH_COUNT_EN
    logic [47:0]    hash_count_q, hash_count_d;
`endif

    logic issue;     // nonce accepted by the core this cycle
    logic res_live;  // result that belongs to the running job
    logic res_dec;   // result that retires an inflight slot
    logic hit;       // returned hash meets the target

    // Core offer: gated from registered state only, so it cannot be withdrawn while in RUN.
    always_comb begin
        core_valid = (state_q == ST_RUN) && !last_issued_q && (inflight_q < MAX_INF);
        core_nonce = nonce_q;
        issue      = core_valid && core_ready;
        res_live   = res_valid && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
        res_dec    = res_live && (inflight_q != 4'd0);
        hit        = (res_hash <= target_q);
    end

    // Next-state, counters and snapshot logic.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d       = state_q;
        midstate_d    = midstate_q;
        header_d      = header_q;
        target_d      = target_q;
        nonce_d       = nonce_q;
        golden_d      = golden_q;
        inflight_d    = inflight_q;
        last_issued_d = last_issued_q;
`ifdef MINE_CTRL_HASH_COUNT_EN
        hash_count_d  = hash_count_q;
        if (res_live && (hash_count_q != '1)) begin
            hash_count_d = hash_count_q + 48'd1;
        end
`endif

        case (state_q)
            ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_ABORTED: begin
                if (start) begin
                    state_d       = ST_LOAD;
                    midstate_d    = midstate_in;
                    header_d      = header_in;
                    target_d      = target_in;
                    nonce_d       = NONCE_FIRST;
                    golden_d      = 32'd0;
                    inflight_d    = 4'd0;
                    last_issued_d = 1'b0;
`ifdef MINE_CTRL_HASH_COUNT_EN
                    hash_count_d  = 48'd0;
`endif
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d    = ST_ABORTED;
                    inflight_d = 4'd0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d    = ST_ABORTED;
                    inflight_d = 4'd0;
                end else begin
                    if (issue) begin
                        // The counter parks on the last nonce instead of wrapping.
                        if (nonce_q == NONCE_LAST) begin
                            last_issued_d = 1'b1;
                        end else begin
                            nonce_d = nonce_q + 32'd1;
                        end
                    end
                    inflight_d = inflight_q + 4'(issue) - 4'(res_dec);
                    if (res_live && hit) begin
                        golden_d = res_nonce;
                        state_d  = ST_DRAIN;
                    end else if (last_issued_d && (inflight_d == 4'd0)) begin
                        state_d = ST_EXHAUSTED;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d    = ST_ABORTED;
                    inflight_d = 4'd0;
                end else begin
                    // Later hits are ignored: the first golden nonce wins.
                    inflight_d = inflight_q - 4'(res_dec);
                    if (inflight_d == 4'd0) begin
                        state_d = ST_FOUND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        nonce_out_d = (state_d == ST_FOUND) ? golden_d : nonce_d;
        found_d     = (state_d == ST_FOUND);
    end

    // State and datapath registers; the wide snapshots are cleared too so reads after reset are defined.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            midstate_q    <= '0;
            header_q      <= '0;
            target_q      <= '0;
            nonce_q       <= '0;
            golden_q      <= '0;
            inflight_q    <= '0;
            last_issued_q <= 1'b0;
            nonce_out_q   <= '0;
            found_q       <= 1'b0;
`ifdef MINE_CTRL_HASH_COUNT_EN
            hash_count_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q       <= state_d;
            midstate_q    <= midstate_d;
            header_q      <= header_d;
            target_q      <= target_d;
            nonce_q       <= nonce_d;
            golden_q      <= golden_d;
            inflight_q    <= inflight_d;
            last_issued_q <= last_issued_d;
            nonce_out_q   <= nonce_out_d;
            found_q       <= found_d;
`ifdef MINE_CTRL_HASH_COUNT_EN
            hash_count_q  <= hash_count_d;
`endif
        end
    end

    assign job_midstate = midstate_q;
    assign job_header   = header_q;
    assign state_out    = state_q;
    assign nonce_out    = nonce_out_q;
    assign found        = found_q;
`ifdef MINE_CTRL_HASH_COUNT_EN
    assign hash_count   = hash_count_q;
`endif

endmodule

// File: tb/tb_mine_ctrl.sv
`timescale 1ns/1ps
// tb_mine_ctrl: directed bench for mine_ctrl. Instance a sweeps nonces 0..7,
// instance b sweeps FFFF_FFFC..FFFF_FFFF. Each has a fixed-latency core model
// whose hash is HIT_HASH (== 5) for nonces selected by a mask, else MISS_HASH.
module tb_mine_ctrl;

    localparam int LAT = 6;
    localparam logic [255:0] HIT_HASH  = 256'd5;
    localparam logic [255:0] MISS_HASH = (256'd1 << 200) | 256'd6;
    localparam logic [255:0] ALL_ONES  = {256{1'b1}};

    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd2;
    localparam logic [2:0] S_FOUND = 3'd4, S_EXH = 3'd5, S_ABORTED = 3'd6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [255:0] midstate_in, target_in;
    logic [95:0]  header_in;

    // instance a
    logic         start_a, abort_a, ready_a, core_valid_a, res_valid_a, found_a;
    logic [31:0]  core_nonce_a, res_nonce_a, nonce_out_a, mask_a;
    logic [255:0] res_hash_a, job_midstate_a;
    logic [95:0]  job_header_a;
    logic [2:0]   state_out_a;
    // instance b
    logic         start_b, abort_b, ready_b, core_valid_b, res_valid_b, found_b;
    logic [31:0]  core_nonce_b, res_nonce_b, nonce_out_b, mask_b;
    logic [255:0] res_hash_b, job_midstate_b;
    logic [95:0]  job_header_b;
    logic [2:0]   state_out_b;
`ifdef MINE_CTRL_HASH_COUNT_EN
    logic [47:0]  hash_count_a, hash_count_b;
`endif

    mine_ctrl #(.NONCE_FIRST(32'h0000_0000), .NONCE_LAST(32'h0000_0007), .MAX_INFLIGHT(4)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .midstate_in(midstate_in), .header_in(header_in), .target_in(target_in),
        .job_midstate(job_midstate_a), .job_header(job_header_a),
        .core_valid(core_valid_a), .core_ready(ready_a), .core_nonce(core_nonce_a),
        .res_valid(res_valid_a), .res_nonce(res_nonce_a), .res_hash(res_hash_a),
        .state_out(state_out_a), .nonce_out(nonce_out_a), .found(found_a)
`ifdef MINE_CTRL_HASH_COUNT_EN
        , .hash_count(hash_count_a)
`endif
    );

    mine_ctrl #(.NONCE_FIRST(32'hFFFF_FFFC), .NONCE_LAST(32'hFFFF_FFFF), .MAX_INFLIGHT(4)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .midstate_in(midstate_in), .header_in(header_in), .target_in(target_in),
        .job_midstate(job_midstate_b), .job_header(job_header_b),
        .core_valid(core_valid_b), .core_ready(ready_b), .core_nonce(core_nonce_b),
        .res_valid(res_valid_b), .res_nonce(res_nonce_b), .res_hash(res_hash_b),
        .state_out(state_out_b), .nonce_out(nonce_out_b), .found(found_b)
`ifdef MINE_CTRL_HASH_COUNT_EN
        , .hash_count(hash_count_b)
`endif
    );

    function automatic logic [255:0] hash_of(input logic [31:0] mask, input logic [31:0] n);
        return mask[n[4:0]] ? HIT_HASH : MISS_HASH;
    endfunction

    // Core model a: fixed-latency pipeline, results in issue order.
    logic [LAT-1:0] pv_a;
    logic [31:0]    pn_a [LAT];
    int             issued_a = 0;
    int             maxpend_a = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv_a <= '0;
            for (int i = 0; i < LAT; i++) pn_a[i] <= '0;
        end else begin
            pv_a    <= {pv_a[LAT-2:0], core_valid_a && ready_a};
            pn_a[0] <= core_nonce_a;
            for (int i = 1; i < LAT; i++) pn_a[i] <= pn_a[i-1];
        end
    end
    always @(posedge clk) begin
        if (core_valid_a && ready_a) issued_a <= issued_a + 1;
        if ($countones(pv_a) > maxpend_a) maxpend_a <= $countones(pv_a);
    end
    assign res_valid_a = pv_a[LAT-1];
    assign res_nonce_a = pn_a[LAT-1];
    assign res_hash_a  = hash_of(mask_a, res_nonce_a);

    // Core model b.
    logic [LAT-1:0] pv_b;
    logic [31:0]    pn_b [LAT];
    int             issued_b = 0;
    int             maxpend_b = 0;
    logic           wrap_b = 1'b0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv_b <= '0;
            for (int j = 0; j < LAT; j++) pn_b[j] <= '0;
        end else begin
            pv_b    <= {pv_b[LAT-2:0], core_valid_b && ready_b};
            pn_b[0] <= core_nonce_b;
            for (int j = 1; j < LAT; j++) pn_b[j] <= pn_b[j-1];
        end
    end
    always @(posedge clk) begin
        if (core_valid_b && ready_b) begin
            issued_b <= issued_b + 1;
            if (core_nonce_b < 32'hFFFF_FFFC) wrap_b <= 1'b1;
        end
        if ($countones(pv_b) > maxpend_b) maxpend_b <= $countones(pv_b);
    end
    assign res_valid_b = pv_b[LAT-1];
    assign res_nonce_b = pn_b[LAT-1];
    assign res_hash_b  = hash_of(mask_b, res_nonce_b);

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a(input string tag, input logic [2:0] st, input int budget);
        int n = 0;
        while (state_out_a !== st && n < budget) begin
            tick();
            n++;
        end
        check(tag, 256'(state_out_a), 256'(st));
    endtask

    task automatic wait_b(input string tag, input logic [2:0] st, input int budget);
        int n = 0;
        while (state_out_b !== st && n < budget) begin
            tick();
            n++;
        end
        check(tag, 256'(state_out_b), 256'(st));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int bad_cnt;
        start_a = 0; abort_a = 0; ready_a = 0; mask_a = 0;
        start_b = 0; abort_b = 0; ready_b = 0; mask_b = 0;
        midstate_in = '0; header_in = '0; target_in = '0;

        // Reset state.
        tick(); tick();
        check("rst_state_a", 256'(state_out_a), 256'(S_IDLE));
        check("rst_valid_a", 256'(core_valid_a), 256'd0);
        check("rst_nonce_out_a", 256'(nonce_out_a), 256'd0);
        check("rst_found_a", 256'(found_a), 256'd0);
        check("rst_midstate_a", job_midstate_a, 256'd0);
        check("rst_state_b", 256'(state_out_b), 256'(S_IDLE));
        reset = 1'b1;
        tick(); tick();

        // Test 1: all hashes hit, first hit is nonce 0, nonces 1..3 drain.
        midstate_in = {8{32'hA5A5_0001}};
        header_in   = {3{32'h1234_5678}};
        target_in   = ALL_ONES;
        mask_a = 32'h0; ready_a = 1'b1;
        base = issued_a;
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("t1_load", 256'(state_out_a), 256'(S_LOAD));
        tick();
        check("t1_run", 256'(state_out_a), 256'(S_RUN));
        check("t1_valid", 256'(core_valid_a), 256'd1);
        check("t1_first_nonce", 256'(core_nonce_a), 256'd0);
        midstate_in = ALL_ONES;
        header_in   = '1;
        wait_a("t1_found", S_FOUND, 40);
        check("t1_golden", 256'(nonce_out_a), 256'd0);
        check("t1_found_flag", 256'(found_a), 256'd1);
        check("t1_issued", 256'(issued_a - base), 256'd4);
        check("t1_snap_midstate", job_midstate_a, {8{32'hA5A5_0001}});
        check("t1_snap_header", 256'(job_header_a), 256'({3{32'h1234_5678}}));

        // Test 2: hits on 5 and 6, first wins; target write mid-job has no effect.
        target_in = 256'd5;
        mask_a = 32'h0000_0060;
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("t2_load", 256'(state_out_a), 256'(S_LOAD));
        check("t2_golden_cleared", 256'(nonce_out_a), 256'd0);
        tick();
        target_in = ALL_ONES;
        wait_a("t2_found", S_FOUND, 80);
        check("t2_golden", 256'(nonce_out_a), 256'd5);
        check("t2_found_flag", 256'(found_a), 256'd1);
`ifdef MINE_CTRL_HASH_COUNT_EN
        check("t2_hash_count", 256'(hash_count_a), 256'd8);
`endif

        // Test 3: core stalls; offer held stable; start in RUN ignored; then exhaust.
        target_in = 256'd0;
        mask_a = 32'h0; ready_a = 1'b0;
        base = issued_a;
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        bad_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (core_valid_a !== 1'b1 || core_nonce_a !== 32'd0) bad_cnt++;
            start_a = (i == 2);
            tick();
        end
        start_a = 1'b0;
        check("t3_stall_stable", 256'(bad_cnt), 256'd0);
        check("t3_start_ignored", 256'(state_out_a), 256'(S_RUN));
        ready_a = 1'b1;
        wait_a("t3_exhausted", S_EXH, 200);
        check("t3_nonce_out", 256'(nonce_out_a), 256'd7);
        check("t3_not_found", 256'(found_a), 256'd0);
        check("t3_issued", 256'(issued_a - base), 256'd8);

        // Test 4: sweep ends at FFFF_FFFF without wrapping.
        target_in = 256'd0;
        mask_b = 32'h0; ready_b = 1'b1;
        base = issued_b;
        start_b = 1'b1; tick(); start_b = 1'b0;
        wait_b("t4_exhausted", S_EXH, 100);
        check("t4_nonce_out", 256'(nonce_out_b), 256'hFFFF_FFFF);
        check("t4_issued", 256'(issued_b - base), 256'd4);
        check("t4_no_wrap", 256'(wrap_b), 256'd0);
        check("t4_not_found", 256'(found_b), 256'd0);

        // Test 5: abort (with simultaneous start) 3 cycles after start, 2 results pending.
        target_in = 256'd0;
        mask_a = 32'h0; ready_a = 1'b1;
        base = issued_a;
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick(); tick();
        abort_a = 1'b1; start_a = 1'b1;
        tick();
        abort_a = 1'b0; start_a = 1'b0;
        check("t5_aborted", 256'(state_out_a), 256'(S_ABORTED));
        check("t5_valid_off", 256'(core_valid_a), 256'd0);
        check("t5_pending", 256'(issued_a - base), 256'd2);
        bad_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (state_out_a !== S_ABORTED || core_valid_a !== 1'b0 || found_a !== 1'b0) bad_cnt++;
            tick();
        end
        check("t5_late_ignored", 256'(bad_cnt), 256'd0);
        // Restart with start+abort together while not running: start wins.
        target_in = 256'd5;
        mask_a = 32'h0000_0004;
        start_a = 1'b1; abort_a = 1'b1; tick(); start_a = 1'b0; abort_a = 1'b0;
        check("t5_restart_load", 256'(state_out_a), 256'(S_LOAD));
        wait_a("t5_restart_found", S_FOUND, 80);
        check("t5_restart_golden", 256'(nonce_out_a), 256'd2);

        // Test 6: reset asserted mid-RUN acts immediately; start after release.
        target_in = 256'd0;
        mask_a = 32'h0; ready_a = 1'b0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        check("t6_run", 256'(state_out_a), 256'(S_RUN));
        check("t6_valid_before", 256'(core_valid_a), 256'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_state", 256'(state_out_a), 256'(S_IDLE));
        check("t6_rst_valid", 256'(core_valid_a), 256'd0);
        check("t6_rst_nonce_out", 256'(nonce_out_a), 256'd0);
        check("t6_rst_state_b", 256'(state_out_b), 256'(S_IDLE));
        tick();
        reset = 1'b1;
        tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("t6_start_after_rst", 256'(state_out_a), 256'(S_LOAD));
        tick();
        abort_a = 1'b1; tick(); abort_a = 1'b0;
        check("t6_abort", 256'(state_out_a), 256'(S_ABORTED));

        check("max_inflight_a", 256'(maxpend_a <= 4), 256'd1);
        check("max_inflight_b", 256'(maxpend_b <= 4), 256'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
